// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg: opcodes, FSM states, owner ids and status bit positions
// shared by the fp_alu_sched scheduler and its fp_alu_iter ALU.
package fp_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_ACC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_FAB  = 1'b1
  } owner_t;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVR     = 1;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/fp_alu_iter.sv
// fp_alu_iter: multi-cycle ALU (ADD/SUB/ACC 1 cycle, MUL W-cycle shift-add).
// Ports: i_clk, i_rst, i_start + i_op/i_a/i_b in; o_done, o_result out.
module fp_alu_iter
  import fp_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_result
);

  localparam int CW = $clog2(W);

  logic          r_busy;
  logic [1:0]    r_op;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_prod;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_addend;
  logic [W-1:0]  w_step;
  logic [W-1:0]  w_acc_sum;

  // r_a is the left-shifting multiplicand, r_b the right-shifting
  // multiplier; the last partial sum is the product.
  assign w_addend  = r_b[0] ? r_a : '0;
  assign w_step    = r_prod + w_addend;
  assign w_acc_sum = r_acc + r_a;

  always_comb begin
    o_result = '0;
    unique case (r_op)
      OP_ADD: o_result = r_a + r_b;
      OP_SUB: o_result = r_a - r_b;
      OP_MUL: o_result = w_step;
      OP_ACC: o_result = w_acc_sum;
      default: o_result = '0;
    endcase
  end

  assign o_done = r_busy &&
    ((r_op != OP_MUL) || (r_cnt == CW'(W-1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_op   <= OP_ADD;
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_op   <= i_op;
      r_a    <= i_a;
      r_b    <= i_b;
      r_prod <= '0;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (o_done) begin
        r_busy <= 1'b0;
        if (r_op == OP_ACC)
          r_acc <= w_acc_sum;
      end else begin
        r_prod <= w_step;
        r_a    <= r_a << 1;
        r_b    <= r_b >> 1;
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_alu_sched.sv
// fp_alu_sched: round-robin host/fabric arbiter in front of fp_alu_iter.
// Ports: okClk/reset; host_* WireIn/WireOut/Trigger side; fab_* req/gnt.
module fp_alu_sched
  import fp_alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic         okClk,
  input  logic         reset,
  input  logic         host_start,
  input  logic         host_clr,
  input  logic [1:0]   host_op,
  input  logic [W-1:0] host_a,
  input  logic [W-1:0] host_b,
  output logic [W-1:0] host_result,
  output logic [31:0]  host_status,
  output logic         host_done,
  input  logic         fab_req,
  input  logic [1:0]   fab_op,
  input  logic [W-1:0] fab_a,
  input  logic [W-1:0] fab_b,
  output logic         fab_gnt,
  output logic         fab_valid,
  output logic [W-1:0] fab_result
);

  state_t           r_state;
  state_t           w_state_nxt;
  owner_t           r_owner;
  owner_t           r_last;
  logic             r_pend;
  logic             r_ovr;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_host_result;
  logic [W-1:0]     r_fab_result;
  logic             r_host_done;
  logic             r_fab_valid;

  logic             w_gnt_host;
  logic             w_gnt_fab;
  logic             w_start;
  logic [1:0]       w_op;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic             w_alu_done;
  logic [W-1:0]     w_alu_res;
  logic             w_busy;

  always_ff @(posedge okClk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_host  = 1'b0;
    w_gnt_fab   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend && fab_req) begin
          if (r_last == OWN_FAB)
            w_gnt_host = 1'b1;
          else
            w_gnt_fab = 1'b1;
        end else if (r_pend) begin
          w_gnt_host = 1'b1;
        end else if (fab_req) begin
          w_gnt_fab = 1'b1;
        end
        if (w_gnt_host || w_gnt_fab)
          w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_alu_done)
          w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_start = w_gnt_host | w_gnt_fab;
  assign w_op    = w_gnt_fab ? fab_op : host_op;
  assign w_a     = w_gnt_fab ? fab_a  : host_a;
  assign w_b     = w_gnt_fab ? fab_b  : host_b;
  assign fab_gnt = w_gnt_fab & ~reset;

  fp_alu_iter #(
    .W(W)
  ) u_iter (
    .i_clk   (okClk),
    .i_rst   (reset),
    .i_start (w_start),
    .i_op    (w_op),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_done  (w_alu_done),
    .o_result(w_alu_res)
  );

  // Results are registered on the EXEC->DONE edge so they and the
  // pulses are visible throughout the DONE cycle.
  always_ff @(posedge okClk) begin
    if (reset) begin
      r_owner       <= OWN_HOST;
      r_last        <= OWN_FAB;
      r_pend        <= 1'b0;
      r_ovr         <= 1'b0;
      r_cnt         <= '0;
      r_host_result <= '0;
      r_fab_result  <= '0;
      r_host_done   <= 1'b0;
      r_fab_valid   <= 1'b0;
    end else begin
      r_host_done <= 1'b0;
      r_fab_valid <= 1'b0;
      r_pend      <= host_start | (r_pend & ~w_gnt_host);
      if (host_clr)
        r_ovr <= 1'b0;
      else if (host_start && r_pend && !w_gnt_host)
        r_ovr <= 1'b1;
      if (w_start) begin
        r_owner <= w_gnt_fab ? OWN_FAB : OWN_HOST;
        r_last  <= w_gnt_fab ? OWN_FAB : OWN_HOST;
      end
      if (r_state == S_EXEC && w_alu_done) begin
        if (r_owner == OWN_HOST) begin
          r_host_result <= w_alu_res;
          r_host_done   <= 1'b1;
          r_cnt         <= r_cnt + CNT_W'(1);
        end else begin
          r_fab_result <= w_alu_res;
          r_fab_valid  <= 1'b1;
        end
      end
    end
  end

  assign w_busy = r_pend ||
    ((r_state != S_IDLE) && (r_owner == OWN_HOST));

  always_comb begin
    host_status = '0;
    host_status[STAT_BUSY] = w_busy;
    host_status[STAT_OVR]  = r_ovr;
    host_status[STAT_CNT_LSB +: CNT_W] = r_cnt;
  end

  assign host_result = r_host_result;
  assign host_done   = r_host_done;
  assign fab_result  = r_fab_result;
  assign fab_valid   = r_fab_valid;

endmodule

// File: tb/tb_fp_alu_sched.sv
// tb_fp_alu_sched: directed + random checks of fp_alu_sched against
// an arithmetic reference model with spec-derived latencies.
module tb_fp_alu_sched;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_start = 1'b0;
  logic        host_clr = 1'b0;
  logic [1:0]  host_op = '0;
  logic [31:0] host_a = '0;
  logic [31:0] host_b = '0;
  logic [31:0] host_result;
  logic [31:0] host_status;
  logic        host_done;
  logic        fab_req = 1'b0;
  logic [1:0]  fab_op = '0;
  logic [31:0] fab_a = '0;
  logic [31:0] fab_b = '0;
  logic        fab_gnt;
  logic        fab_valid;
  logic [31:0] fab_result;

  int vec = 0;
  int errs = 0;
  logic [31:0] acc_m = '0;
  int cnt_m = 0;

  fp_alu_sched #(.W(W), .CNT_W(8)) dut (
    .okClk      (clk),
    .reset      (reset),
    .host_start (host_start),
    .host_clr   (host_clr),
    .host_op    (host_op),
    .host_a     (host_a),
    .host_b     (host_b),
    .host_result(host_result),
    .host_status(host_status),
    .host_done  (host_done),
    .fab_req    (fab_req),
    .fab_op     (fab_op),
    .fab_a      (fab_a),
    .fab_b      (fab_b),
    .fab_gnt    (fab_gnt),
    .fab_valid  (fab_valid),
    .fab_result (fab_result)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: r = a * b;
      default: begin
        acc_m = acc_m + a;
        r = acc_m;
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] idle_status();
    return 32'((cnt_m % 256) << 8);
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    host_start = 1'b0;
    host_clr = 1'b0;
    fab_req = 1'b0;
    tick;
    reset = 1'b0;
    acc_m = '0;
    cnt_m = 0;
  endtask

  task automatic host_run(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    int n;
    tick;
    exp = ref_op(op, a, b);
    lat = (op == 2'd2) ? W + 2 : 3;
    host_op = op;
    host_a = a;
    host_b = b;
    host_start = 1'b1;
    tick;
    host_start = 1'b0;
    n = 1;
    @(negedge clk);
    while (!host_done && n < lat + 8) begin
      @(negedge clk);
      n++;
    end
    cnt_m++;
    chk("host_lat", n, lat);
    chk("host_result", host_result, exp);
    chk("host_cnt", 32'(host_status[15:8]), 32'(cnt_m % 256));
    @(negedge clk);
    chk("host_done_len", 32'(host_done), 32'd0);
    chk("host_status_idle", host_status, idle_status());
  endtask

  task automatic fab_run(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    int n;
    tick;
    exp = ref_op(op, a, b);
    lat = (op == 2'd2) ? W + 1 : 2;
    fab_op = op;
    fab_a = a;
    fab_b = b;
    fab_req = 1'b1;
    @(negedge clk);
    chk("fab_gnt", 32'(fab_gnt), 32'd1);
    tick;
    fab_req = 1'b0;
    n = 1;
    @(negedge clk);
    while (!fab_valid && n < lat + 8) begin
      @(negedge clk);
      n++;
    end
    chk("fab_lat", n, lat);
    chk("fab_result", fab_result, exp);
    @(negedge clk);
    chk("fab_valid_len", 32'(fab_valid), 32'd0);
  endtask

  initial begin : main
    int d1;
    int d2;
    int pulses;
    logic [1:0] hop;
    logic [1:0] fop;
    logic [31:0] ha1, ha2, hb, fa, fb;
    logic [31:0] e_h1, e_h2, e_f;

    tick;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_host_result", host_result, 32'd0);
    chk("rst_status", host_status, 32'd0);
    chk("rst_host_done", 32'(host_done), 32'd0);
    chk("rst_fab_gnt", 32'(fab_gnt), 32'd0);
    chk("rst_fab_valid", 32'(fab_valid), 32'd0);
    chk("rst_fab_result", fab_result, 32'd0);

    host_run(2'd0, 32'h5, 32'h7);
    chk("add_5_7", host_result, 32'h0000000C);

    // MUL with an accepted re-start (c5) and an overrun (c8)
    tick;
    host_op = 2'd2;
    host_a = 32'h00010001;
    host_b = 32'h00010001;
    host_start = 1'b1;
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 2 * W + 10; c++) begin
      tick;
      host_start = (c == 5 || c == 8);
      @(negedge clk);
      if (host_done) begin
        if (d1 == 0) begin
          d1 = c;
          chk("mul_result", host_result, 32'h00020001);
        end else begin
          d2 = c;
          chk("mul2_result", host_result, 32'h00020001);
        end
      end
      if (c == 9)
        chk("ovr_set", 32'(host_status[1]), 32'd1);
    end
    chk("mul_lat", d1, W + 2);
    chk("mul_pend_lat", d2, 2 * W + 4);
    cnt_m += 2;
    tick;
    host_clr = 1'b1;
    tick;
    host_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", host_status, idle_status());

    // tie from reset: host first, then fabric wins the second tie
    do_reset;
    hop = 2'($urandom_range(0, 1));
    fop = 2'($urandom_range(0, 1));
    ha1 = $urandom;
    ha2 = $urandom;
    hb = $urandom;
    fa = $urandom;
    fb = $urandom;
    e_h1 = ref_op(hop, ha1, hb);
    e_f = ref_op(fop, fa, fb);
    e_h2 = ref_op(hop, ha2, hb);
    host_op = hop;
    host_a = ha1;
    host_b = hb;
    fab_op = fop;
    fab_a = fa;
    fab_b = fb;
    for (int c = 0; c < 12; c++) begin
      host_start = (c == 0 || c == 2);
      fab_req = (c >= 1 && c <= 4);
      if (c == 3)
        host_a = ha2;
      @(negedge clk);
      chk("tie_fab_gnt", 32'(fab_gnt), 32'(c == 4));
      chk("tie_fab_valid", 32'(fab_valid), 32'(c == 6));
      chk("tie_host_done", 32'(host_done), 32'(c == 3 || c == 9));
      if (c == 3)
        chk("tie_host1", host_result, e_h1);
      if (c == 6)
        chk("tie_fab", fab_result, e_f);
      if (c == 9)
        chk("tie_host2", host_result, e_h2);
      tick;
    end
    host_start = 1'b0;
    fab_req = 1'b0;
    cnt_m += 2;

    // shared accumulator
    do_reset;
    host_run(2'd3, 32'd3, $urandom);
    chk("acc_3", host_result, 32'd3);
    fab_run(2'd3, 32'd4, $urandom);
    chk("acc_7", fab_result, 32'd7);
    host_run(2'd3, 32'hFFFFFFFD, $urandom);
    chk("acc_wrap", host_result, 32'd4);

    fab_run(2'd1, 32'd0, 32'd1);
    chk("sub_0_1", fab_result, 32'hFFFFFFFF);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1)
        host_run(2'($urandom_range(0, 3)), $urandom, $urandom);
      else
        fab_run(2'($urandom_range(0, 3)), $urandom, $urandom);
    end

    // reset in the middle of a host MUL with a command pending
    tick;
    host_op = 2'd2;
    host_a = $urandom;
    host_b = $urandom | 32'd1;
    host_start = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 50; c++) begin
      tick;
      host_start = (c == 10);
      reset = (c == 12);
      @(negedge clk);
      if (host_done || fab_valid)
        pulses++;
      if (c == 13) begin
        chk("abort_host_result", host_result, 32'd0);
        chk("abort_status", host_status, 32'd0);
        chk("abort_fab_result", fab_result, 32'd0);
      end
    end
    chk("abort_pulses", pulses, 0);
    acc_m = '0;
    cnt_m = 0;
    host_run(2'd0, $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
